// File: rtl/rf_access_arbiter_if.sv
// Interface bundling the requester-side handshake and the register file ports
// of rf_access_arbiter.
//   slave  : the arbiter (receives requests, drives the register file)
//   master : requesters plus register file (drive requests and rf_r1_dout)
// Signals:
//   req/req_we/req_addr/req_wdata  per-requester request, flattened by index
//   gnt/ack/rdata/busy             arbitration result and completion
//   rf_r1_addr/rf_r1_dout          register file read port 1 (registered in rf)
//   rf_r3_addr/rf_r3_din/rf_r3_wr  register file write port
interface rf_access_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [5:0]                rf_r1_addr;
  logic [5:0]                rf_r3_addr;
  logic [DATA_W-1:0]         rf_r3_din;
  logic                      rf_r3_wr;
  logic [DATA_W-1:0]         rf_r1_dout;

  modport slave (
    input  req, req_we, req_addr, req_wdata, rf_r1_dout,
    output gnt, ack, rdata, busy, rf_r1_addr, rf_r3_addr, rf_r3_din, rf_r3_wr
  );

  modport master (
    output req, req_we, req_addr, req_wdata, rf_r1_dout,
    input  gnt, ack, rdata, busy, rf_r1_addr, rf_r3_addr, rf_r3_din, rf_r3_wr
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one register file between NUM_REQ requesters.
// Each request is a single read or write; a small FSM sequences the rf write
// port (one-cycle write strobe) and the registered read port 1.
// Ports:
//   clk   system clock, all state on posedge
//   rst   asynchronous active-high reset
//   bus   rf_access_arbiter_if.slave: requests in, gnt/ack/rdata/busy out,
//         register file read-port-1 and write-port signals
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate and latch the winning request
// WRITE  | rf_r3_wr high for this single cycle with latched addr/data
// READ   | rf_r1_addr presented; rf captures read data on this edge
// RCAP   | rdata captured from rf_r1_dout at the end of this cycle
// RESP   | ack pulse to the owner; gnt/ack clear on the way back to IDLE
module rf_access_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_access_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RCAP,
    S_RESP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               win_found;
  int                 cand;

  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               busy_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [5:0]         r1_addr_q;
  logic [5:0]         r3_addr_q;
  logic [DATA_W-1:0]  r3_din_q;
  logic               r3_wr_q;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  // Search starts one past the last winner so a held requester cannot
  // starve the others.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      gnt_q     <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      r1_addr_q <= '0;
      r3_addr_q <= '0;
      r3_din_q  <= '0;
      r3_wr_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt_q  <= NUM_REQ'(1) << win_idx;
            rr_ptr <= win_idx;
            busy_q <= 1'b1;
            // Address/data are captured here, so later changes on the
            // requester side cannot affect the committed transaction.
            if (bus.req_we[win_idx]) begin
              r3_addr_q <= 6'(addr_arr[win_idx]);
              r3_din_q  <= wdata_arr[win_idx];
              r3_wr_q   <= 1'b1;
              state     <= S_WRITE;
            end else begin
              r1_addr_q <= 6'(addr_arr[win_idx]);
              state     <= S_READ;
            end
          end
        end
        S_WRITE: begin
          r3_wr_q <= 1'b0;
          ack_q   <= gnt_q;
          state   <= S_RESP;
        end
        S_READ: begin
          state <= S_RCAP;
        end
        S_RCAP: begin
          rdata_q <= bus.rf_r1_dout;
          ack_q   <= gnt_q;
          state   <= S_RESP;
        end
        S_RESP: begin
          gnt_q  <= '0;
          ack_q  <= '0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          r3_wr_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.rdata      = rdata_q;
  assign bus.rf_r1_addr = r1_addr_q;
  assign bus.rf_r3_addr = r3_addr_q;
  assign bus.rf_r3_din  = r3_din_q;
  assign bus.rf_r3_wr   = r3_wr_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Testbench for rf_access_arbiter with four requesters and a behavioural
// register file (registered read port 1, write port 3).
module tb_rf_access_arbiter;

  localparam int NR = 4;

  typedef struct {
    int          idx;
    bit          rd;
    int          lat;
    logic [31:0] data;
  } ack_exp_t;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk;
  logic rst;

  rf_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(5), .DATA_W(32)) ifc();

  rf_access_arbiter #(.NUM_REQ(NR), .ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];

  always @(posedge clk) begin
    if (ifc.rf_r3_wr) mem[ifc.rf_r3_addr] <= ifc.rf_r3_din;
    else              ifc.rf_r1_dout <= mem[ifc.rf_r1_addr];
  end

  int checks = 0;
  int errors = 0;

  ack_exp_t ack_q [$];
  wr_exp_t  wr_q  [$];
  int       gaps  [$];
  int       exp_order [$];

  bit          we_cfg   [NR];
  logic [4:0]  addr_cfg [NR];
  logic [31:0] data_cfg [NR];

  bit mon_en       = 1'b0;
  bit prev_ack     = 1'b0;
  int cyc          = 0;
  int gnt_len      = 0;
  int ack_count    = 0;
  int wr_cycles    = 0;
  int last_ack_cyc = 0;

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    ack_exp_t    e;
    wr_exp_t     w;
    logic [3:0]  oh;
    cyc++;
    if (mon_en) begin
      checks++;
      if (!$onehot0(ifc.gnt) || ((ifc.gnt != 4'b0) !== ifc.busy)) begin
        errors++;
        $display("FAIL gnt_busy: gnt=%b busy=%b, required one-hot gnt matching busy", ifc.gnt, ifc.busy);
      end
      if (ifc.gnt != 4'b0) gnt_len++;
      if (ifc.rf_r3_wr) begin
        wr_cycles++;
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: addr=%h din=%h, required no write", ifc.rf_r3_addr, ifc.rf_r3_din);
        end else begin
          w = wr_q.pop_front();
          if (ifc.rf_r3_addr !== w.addr || ifc.rf_r3_din !== w.data) begin
            errors++;
            $display("FAIL wr_port: addr=%h din=%h, required addr=%h din=%h",
                     ifc.rf_r3_addr, ifc.rf_r3_din, w.addr, w.data);
          end
        end
      end
      if (ifc.ack != 4'b0) begin
        ack_count++;
        checks++;
        gaps.push_back(cyc - last_ack_cyc);
        last_ack_cyc = cyc;
        if (ack_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: ack=%b, required no ack", ifc.ack);
        end else begin
          e = ack_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          if (ifc.ack !== oh || ifc.gnt !== oh || prev_ack) begin
            errors++;
            $display("FAIL ack_owner: ack=%b gnt=%b prev_ack=%0d, required ack=gnt=%b single pulse",
                     ifc.ack, ifc.gnt, prev_ack, oh);
          end
          if (gnt_len != e.lat) begin
            errors++;
            $display("FAIL latency: %0d cycles, required %0d", gnt_len, e.lat);
          end
          if (e.rd && ifc.rdata !== e.data) begin
            errors++;
            $display("FAIL rdata: %h, required %h", ifc.rdata, e.data);
          end
        end
      end
      prev_ack = (ifc.ack != 4'b0);
      if (!ifc.busy) gnt_len = 0;
    end
  end

  task automatic do_reset();
    ifc.req = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic push_exp(input int idx, input bit we, input logic [4:0] addr, input logic [31:0] wdata);
    ack_exp_t e;
    wr_exp_t  w;
    e.idx  = idx;
    e.rd   = !we;
    e.lat  = we ? 2 : 3;
    e.data = shadow[addr];
    ack_q.push_back(e);
    if (we) begin
      w.addr = {1'b0, addr};
      w.data = wdata;
      wr_q.push_back(w);
      shadow[addr] = wdata;
    end
  endtask

  // mode 0: normal, 1: drop req right after grant, 2: scramble addr/wdata after grant
  task automatic run_op(input int idx, input bit we, input logic [4:0] addr,
                        input logic [31:0] wdata, input int mode);
    int target;
    bit granted;
    granted = 1'b0;
    push_exp(idx, we, addr, wdata);
    target = ack_count + 1;
    ifc.req_we[idx] = we;
    ifc.req_addr[idx*5 +: 5] = addr;
    ifc.req_wdata[idx*32 +: 32] = wdata;
    ifc.req[idx] = 1'b1;
    for (int c = 0; c < 20 && ack_count < target; c++) begin
      @(negedge clk);
      #1;
      if (ifc.gnt[idx]) granted = 1'b1;
      if (granted && mode == 1) ifc.req[idx] = 1'b0;
      if (granted && mode == 2) begin
        ifc.req_addr[idx*5 +: 5] = addr ^ 5'h1F;
        ifc.req_wdata[idx*32 +: 32] = $urandom;
      end
    end
    ifc.req[idx] = 1'b0;
    checks++;
    if (ack_count < target) begin
      errors++;
      $display("FAIL op_timeout: acks=%0d, required %0d", ack_count, target);
    end
  endtask

  task automatic run_held(input logic [3:0] mask);
    int target;
    int n;
    n = exp_order.size();
    foreach (exp_order[k]) push_exp(exp_order[k], we_cfg[exp_order[k]],
                                    addr_cfg[exp_order[k]], data_cfg[exp_order[k]]);
    target = ack_count + n;
    for (int i = 0; i < NR; i++) begin
      ifc.req_we[i] = we_cfg[i];
      ifc.req_addr[i*5 +: 5] = addr_cfg[i];
      ifc.req_wdata[i*32 +: 32] = data_cfg[i];
    end
    ifc.req = mask;
    for (int c = 0; c < n*6 + 10 && ack_count < target; c++) begin
      @(negedge clk);
      #1;
    end
    ifc.req = '0;
    checks++;
    if (ack_count < target) begin
      errors++;
      $display("FAIL held_timeout: acks=%0d, required %0d", ack_count, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    #1;
    checks++;
    if (ifc.gnt !== 4'b0 || ifc.ack !== 4'b0 || ifc.busy !== 1'b0 || ifc.rf_r3_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b ack=%b busy=%b wr=%b, required all 0",
               ifc.gnt, ifc.ack, ifc.busy, ifc.rf_r3_wr);
    end
    checks++;
    if (ifc.rdata !== 32'h0 || ifc.rf_r1_addr !== 6'h0 || ifc.rf_r3_addr !== 6'h0 || ifc.rf_r3_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h r1=%h r3=%h din=%h, required all 0",
               ifc.rdata, ifc.rf_r1_addr, ifc.rf_r3_addr, ifc.rf_r3_din);
    end
  endtask

  task automatic test_write_read();
    int wr0;
    wr0 = wr_cycles;
    run_op(0, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    checks++;
    if (wr_cycles - wr0 != 1) begin
      errors++;
      $display("FAIL write_strobe: %0d write cycles, required 1", wr_cycles - wr0);
    end
    run_op(0, 1'b0, 5'd5, 32'h0, 0);
    checks++;
    if (wr_cycles - wr0 != 1) begin
      errors++;
      $display("FAIL read_no_write: %0d write cycles, required 1", wr_cycles - wr0);
    end
    run_op(0, 1'b1, 5'd6, 32'h12345678, 0);
    @(negedge clk);
    #1;
    checks++;
    if (ifc.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rdata_hold: %h, required %h", ifc.rdata, 32'hDEADBEEF);
    end
  endtask

  task automatic test_contention();
    int wr0;
    do_reset();
    wr0 = wr_cycles;
    we_cfg[0] = 1'b1; addr_cfg[0] = 5'd10; data_cfg[0] = 32'hA0A0_0001;
    we_cfg[1] = 1'b1; addr_cfg[1] = 5'd11; data_cfg[1] = 32'hB1B1_0002;
    exp_order = '{0, 1, 0, 1};
    run_held(4'b0011);
    checks++;
    if (wr_cycles - wr0 != 4) begin
      errors++;
      $display("FAIL contention_writes: %0d write cycles, required 4", wr_cycles - wr0);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NR; i++) begin
      we_cfg[i]   = 1'b0;
      addr_cfg[i] = 5'(i + 1);
      data_cfg[i] = 32'h0;
    end
    exp_order = '{0, 1, 2, 3, 0};
    run_held(4'b1111);
    addr_cfg[2] = 5'd3;
    exp_order = '{2, 2, 2};
    gaps.delete();
    run_held(4'b0100);
    checks++;
    if (gaps.size() != 3) begin
      errors++;
      $display("FAIL single_count: %0d acks, required 3", gaps.size());
    end else if (gaps[1] != 4 || gaps[2] != 4) begin
      errors++;
      $display("FAIL single_gap: gaps %0d,%0d, required 4,4", gaps[1], gaps[2]);
    end
  endtask

  task automatic test_withdrawal();
    run_op(1, 1'b0, 5'd7, 32'h0, 1);
  endtask

  task automatic test_hold();
    run_op(2, 1'b0, 5'd9, 32'h0, 2);
  endtask

  task automatic test_reset_mid_write();
    wr_exp_t w;
    bit      seen;
    seen = 1'b0;
    w.addr = 6'd20;
    w.data = 32'h55AA55AA;
    wr_q.push_back(w);
    ifc.req_we[0] = 1'b1;
    ifc.req_addr[4:0] = 5'd20;
    ifc.req_wdata[31:0] = 32'h55AA55AA;
    ifc.req[0] = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (ifc.gnt[0]) seen = 1'b1;
    end
    checks++;
    if (!seen || ifc.rf_r3_wr !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_setup: granted=%0d wr=%b, required 1 and 1", seen, ifc.rf_r3_wr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.rf_r3_wr !== 1'b0 || ifc.gnt !== 4'b0 || ifc.busy !== 1'b0 || ifc.ack !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: wr=%b gnt=%b busy=%b ack=%b, required all 0",
               ifc.rf_r3_wr, ifc.gnt, ifc.busy, ifc.ack);
    end
    ifc.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    we_cfg[0] = 1'b1; addr_cfg[0] = 5'd21; data_cfg[0] = 32'hC0DE_0021;
    we_cfg[1] = 1'b1; addr_cfg[1] = 5'd22; data_cfg[1] = 32'hC0DE_0022;
    exp_order = '{0, 1};
    run_held(4'b0011);
  endtask

  initial begin
    rst = 1'b0;
    ifc.req = '0;
    ifc.req_we = '0;
    ifc.req_addr = '0;
    ifc.req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]   <= 32'h1000_0000 | (i * 32'h0101);
      shadow[i] = 32'h1000_0000 | (i * 32'h0101);
    end

    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_withdrawal();
    test_hold();
    test_reset_mid_write();

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ack_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d acks and %0d writes outstanding, required 0 and 0",
               ack_q.size(), wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
